// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage slice.
// Used by the decoder, the stage top and its interface.
package alu_stage_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_OP_AND = 4'b0000;
  localparam logic [3:0] ALU_OP_OR  = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD = 4'b0010;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;
  localparam logic [3:0] ALU_OP_SLT = 4'b0111;

  typedef struct packed {
    logic op1;
    logic op2;
    logic sub;
    logic cin;
    logic err;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Request and result handshakes of the ALU issue stage.
// ALU_ISSUE_OVF_EN adds the res_ovf result flag.
interface alu_issue_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_err;
`ifdef ALU_ISSUE_OVF_EN
  logic             res_ovf;
`endif

  modport master (
    output in_valid, in_op, in_a, in_b,
    input  in_ready,
    input  res_valid, res_data,
    input  res_zero, res_err,
`ifdef ALU_ISSUE_OVF_EN
    input  res_ovf,
`endif
    output res_ready
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b,
    output in_ready,
    output res_valid, res_data,
    output res_zero, res_err,
`ifdef ALU_ISSUE_OVF_EN
    output res_ovf,
`endif
    input  res_ready
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Op code to ALU control bundle.
// Unknown codes fall back to AND and raise err.
module alu_ctrl_decode
  import alu_stage_pkg::*;
(
  input  logic [3:0] in_op,
  output alu_ctrl_t  ctrl
);

  // map op code to {op1,op2,sub,cin,err}
  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (in_op == ALU_OP_AND): ctrl = '0;
      (in_op == ALU_OP_OR): begin
        ctrl.op2 = 1'b1;
      end
      (in_op == ALU_OP_ADD): begin
        ctrl.op1 = 1'b1;
      end
      (in_op == ALU_OP_SUB): begin
        ctrl.op1 = 1'b1;
        ctrl.sub = 1'b1;
        ctrl.cin = 1'b1;
      end
      (in_op == ALU_OP_SLT): begin
        ctrl.op1 = 1'b1;
        ctrl.op2 = 1'b1;
        ctrl.sub = 1'b1;
        ctrl.cin = 1'b1;
      end
      default: ctrl.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-register issue stage in front of thirty_two_alu.
// ALU_ISSUE_OVF_EN adds a registered signed-overflow flag.
module alu_issue_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_stage_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [WIDTH-1:0] alu_sub,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic [WIDTH-1:0] alu_sum
);

  alu_ctrl_t        dec;
  logic             s0_valid;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  alu_ctrl_t        s0_ctrl;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_zero;
  logic             s1_err;
  logic             s1_free;
  logic             s0_adv;
  logic             accept;

  alu_ctrl_decode u_dec (
    .in_op (bus.in_op),
    .ctrl  (dec)
  );

  assign s1_free = !s1_valid || bus.res_ready;
  assign s0_adv = s0_valid && s1_free;
  assign bus.in_ready = !s0_valid || s1_free;
  assign accept = bus.in_valid && bus.in_ready;

  // issue register; operands only load on accept so
  // the ALU inputs hold their last values when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_a <= '0;
      s0_b <= '0;
      s0_ctrl <= '0;
    end else begin
      if (accept) begin
        s0_valid <= 1'b1;
        s0_a <= bus.in_a;
        s0_b <= bus.in_b;
        s0_ctrl <= dec;
      end else if (s0_adv) begin
        s0_valid <= 1'b0;
      end
    end
  end

  assign alu_a = s0_a;
  assign alu_b = s0_b;
  assign alu_op1 = {WIDTH{s0_ctrl.op1}};
  assign alu_op2 = {WIDTH{s0_ctrl.op2}};
  assign alu_sub = {WIDTH{s0_ctrl.sub}};
  assign alu_cin = s0_ctrl.cin;

`ifdef ALU_ISSUE_OVF_EN
  logic s0_is_add;
  logic sgn_a;
  logic sgn_b;
  logic sgn_s;
  logic ovf_nxt;
  logic s1_ovf;
  logic unused_cout;

  assign sgn_a = s0_a[WIDTH-1];
  assign sgn_b = s0_b[WIDTH-1];
  assign sgn_s = alu_sum[WIDTH-1];
  assign s0_is_add = s0_ctrl.op1 && !s0_ctrl.op2
                   && !s0_ctrl.sub;
  assign ovf_nxt = s0_is_add ?
      (sgn_a == sgn_b) && (sgn_s != sgn_a) :
    s0_ctrl.sub ?
      (sgn_a != sgn_b) && (sgn_s != sgn_a) :
      1'b0;
  assign unused_cout = alu_cout;

  // overflow flag travels with the S1 result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ovf <= 1'b0;
    end else if (s0_adv) begin
      s1_ovf <= ovf_nxt;
    end
  end

  assign bus.res_ovf = s1_ovf;
`else
  logic unused_alu;
  assign unused_alu = ^{alu_cout, alu_sum};
`endif

  // result register; payload frozen until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_zero <= 1'b0;
      s1_err <= 1'b0;
    end else begin
      if (s0_adv) begin
        s1_valid <= 1'b1;
        s1_data <= s0_ctrl.err ? '0 : alu_out;
        s1_zero <= s0_ctrl.err ? 1'b1 : alu_zero;
        s1_err <= s0_ctrl.err;
      end else if (bus.res_ready) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign bus.res_valid = s1_valid;
  assign bus.res_data = s1_data;
  assign bus.res_zero = s1_zero;
  assign bus.res_err = s1_err;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Pipeline stage that sits directly upstream of `thirty_two_alu`. It accepts ALU requests (4-bit op code plus two 32-bit operands) over a valid/ready handshake and registers them. It decodes the op into the ALU's replicated `op1`/`op2`/`sub` control vectors and `cin`, drives the combinational ALU from that register, and captures `out`/`zero` in a result register. Results leave over a second valid/ready handshake. Throughput is one request per cycle.

## Interface
- `WIDTH`, 32: operand/result width; must match the ALU (32).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage accepts request this cycle.
- `in_op`  in  4  op code (AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111).
- `in_a`, `in_b`  in  WIDTH  operands.
- `alu_a`, `alu_b`  out  WIDTH  to ALU `a`, `b`.
- `alu_op1`, `alu_op2`, `alu_sub`  out  WIDTH  to ALU; each is the decoded bit replicated across all bits.
- `alu_cin`  out  1  to ALU `cin`.
- `alu_out`  in  WIDTH  from ALU `out`.
- `alu_zero`  in  1  from ALU `zero`.
- `alu_cout`  in  1  from ALU `cout`.
- `alu_sum`  in  WIDTH  from ALU `sum`; used only by the overflow feature.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  WIDTH  registered ALU result.
- `res_zero`  out  1  registered zero flag.
- `res_err`  out  1  the request had an illegal op code.

## Operation
- Decode of `{op1,op2,sub,cin}` per op:
  - AND: 0,0,0,0
  - OR: 0,1,0,0
  - ADD: 1,0,0,0
  - SUB: 1,0,1,1
  - SLT: 1,1,1,1
- Any other op code decodes as AND with `err`=1. For that request, `res_data` is forced to 0 and `res_zero` to 1.
- S0 (issue register): holds `valid`, `a`, `b`, decoded controls and `err`.
  - S0 drives the `alu_*` outputs continuously.
  - While S0 is empty, the `alu_*` outputs hold their last values.
- S1 (result register): holds `valid`, `data`, `zero`, `err` (and `ovf` when the overflow feature is enabled).
  - Captures the combinational ALU outputs in the same cycle S0 advances into it.
- Advance rules:
  - `s1_free = !s1_valid || res_ready`
  - `s0_adv = s0_valid && s1_free`
  - `in_ready = !s0_valid || s1_free`
- Handshakes:
  - A transfer occurs on a clock edge with valid && ready.
  - Once `res_valid` is high, `res_data`/`res_zero`/`res_err` stay stable until accepted.
  - `in_ready` must not depend on `in_valid`.
- Simultaneous accept into S0 and advance of S0 to S1 on the same edge is legal; no bubble is inserted.
- No request is reordered, dropped or duplicated.

## Timing
- Latency: a request accepted at edge N is presented on `res_*` after edge N+1 if S1 is free, i.e. 2 cycles input to output.
- Throughput is 1 per cycle when `res_ready` is held high.
- When `res_ready` is low, at most two requests are held (S0 and S1). `in_ready` falls in the cycle after S0 fills behind a stalled S1.
- Reset values: `res_valid`=0, `res_data`=0, `res_zero`=0, `res_err`=0, `in_ready`=1, `alu_*`=0.
- Reset asserted mid-operation discards both stages immediately and asynchronously; no partial result is emitted after release.

## Configuration
- `ALU_ISSUE_OVF_EN` defined:
  - Adds output `res_ovf` (1 bit), registered in S1.
  - For ADD, `res_ovf` = (`a[31]`==`b[31]`) && (`alu_sum[31]`!=`a[31]`).
  - For SUB and SLT, `res_ovf` = (`a[31]`!=`b[31]`) && (`alu_sum[31]`!=`a[31]`).
  - For all other ops, `res_ovf` = 0. Reset value 0.
- `ALU_ISSUE_OVF_EN` undefined: no `res_ovf` port, and `alu_sum` is unused.

## Structure
- Shared package `alu_stage_pkg` holds:
  - the op-code constants `ALU_OP_AND`/`OR`/`ADD`/`SUB`/`SLT`;
  - the control-bundle typedef `alu_ctrl_t` {`op1`, `op2`, `sub`, `cin`, `err`};
  - `ALU_WIDTH` = 32.
- Sub-module `alu_ctrl_decode`: purely combinational, `in_op` to `alu_ctrl_t`. Instantiated once, ahead of S0.

## Test plan
- Reset, then AND a=40 b=10 with `res_ready`=1 -> `res_data`=8, `res_zero`=0, `res_err`=0, 2 cycles after accept.
- Back-to-back OR 40/10, ADD 40/10, SUB 40/10, SLT 10/40 on consecutive cycles -> results 42, 50, 30, 1 on consecutive cycles; `alu_cin`=1 only for SUB/SLT.
- SUB a=60 b=60 -> `res_data`=0, `res_zero`=1.
- Hold `res_ready`=0 while sending 3 requests -> `in_ready` falls after 2 are accepted, `res_data` holds the first result; release -> all 3 results emerge in order with no loss.
- Op 1111 with a=5 b=3 -> `res_err`=1, `res_data`=0, `res_zero`=1; the next legal request is unaffected.
- Assert `rst_n` low while both stages are full -> `res_valid`=0 immediately; after release no stale result appears. With `ALU_ISSUE_OVF_EN`, ADD 0x7FFFFFFF+1 -> `res_ovf`=1.
